// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - control-unit memory strobes to word-wide valid/grant/rvalid bus bridge
//
// Purpose:
//   Turns one mem_rden/mem_wren request from the core control unit into a
//   single transaction on a word-wide request/grant/rvalid bus. Store data is
//   lane-replicated with byte enables, load data is shifted and sign/zero
//   extended, misaligned or contradictory requests and stalled bus cycles are
//   reported as a one-cycle fault pulse. Completion is a one-cycle rsp_valid.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_rd/req_wr  read / write strobes, held by control until rsp_valid
//   req_fetch      read is an instruction fetch (word, funct3 ignored)
//   req_addr       byte address
//   req_wdata      right-justified store data
//   req_funct3     access size/sign (LB LH LW LBU LHU / SB SH SW)
//   busy           transaction in flight
//   rsp_valid      one-cycle completion pulse
//   rsp_rdata      extended load/fetch data, held until the next read response
//   fault          one-cycle pulse: misaligned, rd&wr, or bus timeout
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus request, held until bus_gnt
//   bus_gnt        request accepted this cycle
//   bus_rvalid     read data valid (any cycle after the grant)
//   bus_rdata      raw read word

module mem_bridge #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              busy,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    // The timeout counter only needs to reach TIMEOUT_CYC; with TIMEOUT_CYC=0
    // the check is disabled and a 1-bit counter just wraps harmlessly.
    localparam int               CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam bit               TO_EN    = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Registered state and outputs
    state_t            r_state;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_fault;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [XLEN-1:0]   r_bus_wdata;
    logic [CNT_W-1:0]  r_cnt;
    // Latched load shaping info, consumed when read data returns
    logic [1:0]        r_off;
    size_t             r_ld_size;
    logic              r_ld_sign;

    // Next-state values
    state_t            w_state_nxt;
    logic              w_rsp_valid_nxt;
    logic [XLEN-1:0]   w_rsp_rdata_nxt;
    logic              w_fault_nxt;
    logic              w_bus_req_nxt;
    logic              w_bus_we_nxt;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic [3:0]        w_bus_be_nxt;
    logic [XLEN-1:0]   w_bus_wdata_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_off_nxt;
    size_t             w_ld_size_nxt;
    logic              w_ld_sign_nxt;

    // Request decode
    size_t             w_in_size;
    logic [1:0]        w_in_off;
    logic              w_misalign;
    logic [3:0]        w_in_be;
    logic [XLEN-1:0]   w_in_wdata;

    // Response shaping and timeout
    logic [XLEN-1:0]   w_rd_shift;
    logic [XLEN-1:0]   w_ld_ext;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;

    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign fault     = r_fault;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

    // Access size: fetches are always words; otherwise funct3[1:0] selects
    // B/H/W and any undefined encoding falls back to a word access.
    always_comb begin
        w_in_off  = req_addr[1:0];
        w_in_size = SZ_WORD;
        if (!(req_rd && req_fetch)) begin
            case (req_funct3[1:0])
                2'b00:   w_in_size = SZ_BYTE;
                2'b01:   w_in_size = SZ_HALF;
                default: w_in_size = SZ_WORD;
            endcase
        end

        w_misalign = ((w_in_size == SZ_HALF) && req_addr[0]) ||
                     ((w_in_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

        // Data is replicated across all lanes so the enabled lanes always
        // see the right bytes regardless of offset.
        case (w_in_size)
            SZ_BYTE: begin
                w_in_be    = 4'b0001 << w_in_off;
                w_in_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_in_be    = 4'b0011 << w_in_off;
                w_in_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_in_be    = 4'b1111;
                w_in_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction from the raw bus word using the latched offset/size.
    always_comb begin
        w_rd_shift = bus_rdata >> {r_off, 3'b000};
        case (r_ld_size)
            SZ_BYTE: w_ld_ext = {{(XLEN-8){r_ld_sign & w_rd_shift[7]}}, w_rd_shift[7:0]};
            SZ_HALF: w_ld_ext = {{(XLEN-16){r_ld_sign & w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_ld_ext = bus_rdata;
        endcase
    end

    // Counter value after this cycle; hitting the limit aborts the access.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = TO_EN && (w_cnt_inc == TO_LIMIT);

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_fault_nxt     = 1'b0;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_be_nxt    = r_bus_be;
        w_bus_wdata_nxt = r_bus_wdata;
        w_cnt_nxt       = '0;
        w_off_nxt       = r_off;
        w_ld_size_nxt   = r_ld_size;
        w_ld_sign_nxt   = r_ld_sign;

        case (r_state)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    if ((req_rd && req_wr) || w_misalign) begin
                        // Rejected without touching the bus.
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_REQ;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = req_wr;
                        w_bus_addr_nxt  = {req_addr[ADDR_W-1:2], 2'b00};
                        w_bus_be_nxt    = req_wr ? w_in_be : 4'b1111;
                        w_bus_wdata_nxt = w_in_wdata;
                        w_off_nxt       = w_in_off;
                        w_ld_size_nxt   = w_in_size;
                        w_ld_sign_nxt   = ~req_funct3[2];
                    end
                end
            end
            ST_REQ: begin
                // A grant in the same cycle as the timeout still completes.
                if (bus_gnt) begin
                    w_bus_req_nxt = 1'b0;
                    if (r_bus_we) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else if (w_timeout) begin
                    w_fault_nxt   = 1'b1;
                    w_bus_req_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    w_rsp_rdata_nxt = w_ld_ext;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else if (w_timeout) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_fault     <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= '0;
            r_cnt       <= '0;
            r_off       <= 2'b00;
            r_ld_size   <= SZ_WORD;
            r_ld_sign   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_fault     <= w_fault_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_be    <= w_bus_be_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_off       <= w_off_nxt;
            r_ld_size   <= w_ld_size_nxt;
            r_ld_sign   <= w_ld_sign_nxt;
        end
    end

endmodule
